// File: rtl/stock_manager_if.sv
// stock_manager_if
//   Front-panel bus for stock_manager: keypad pulses and channel select in,
//   per-channel counts, entry value and status out.
//   master: keypad/switch side (drives sel, key_edge)
//   slave : stock_manager (drives rest, room, operand, done, err)
//   rest/room pack channel i at [i*CNT_W +: CNT_W].
interface stock_manager_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 4,
    parameter int OP_W  = CNT_W + 4
);
    logic [CH-1:0]       sel;
    logic [15:0]         key_edge;
    logic [CH*CNT_W-1:0] rest;
    logic [CH*CNT_W-1:0] room;
    logic [OP_W-1:0]     operand;
    logic                done;
    logic                err;

    modport master (output sel, key_edge, input rest, room, operand, done, err);
    modport slave  (input sel, key_edge, output rest, room, operand, done, err);
endinterface

// File: rtl/stock_manager.sv
// stock_manager
//   Per-channel stock counters driven by keypad entry. Digits build a decimal
//   operand; A adds it, B takes it, D refills, C clears. The command acts on
//   the channel picked by the one-hot sel switches.
//   Ports: clk, rst_n (async, active low), bus (stock_manager_if.slave).
//   Optional feature macro: STOCK_SATURATE_EN -- oversized add/take clamp the
//   count to CAPACITY/0 instead of raising err.

// One counter lane. Evaluates whether the operand fits this channel and
// commits the new count when the top-level asserts go.
module stock_lane #(
    parameter int CNT_W    = 4,
    parameter int CAPACITY = 15,
    parameter int OP_W     = CNT_W + 4,
    parameter bit SAT      = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [1:0]       op,       // 0 add, 1 take, 2 fill
    input  logic [OP_W-1:0]  operand,
    output logic [CNT_W-1:0] rest,
    output logic [CNT_W-1:0] room,
    output logic             fits
);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic [OP_W:0]      ext_op, ext_rest, ext_room;
    logic [CNT_W-1:0]   nxt;

    assign room     = CAP - rest;
    // Compare one bit wider than the operand so nothing can wrap.
    assign ext_op   = (OP_W+1)'(operand);
    assign ext_rest = (OP_W+1)'(rest);
    assign ext_room = (OP_W+1)'(room);

    always_comb begin
        fits = 1'b1;
        nxt  = rest;
        case (op)
            2'd0: begin
                fits = (ext_op <= ext_room);
                // Low bits are exact whenever the operand fits.
                nxt  = fits ? rest + operand[CNT_W-1:0] : CAP;
            end
            2'd1: begin
                fits = (ext_op <= ext_rest);
                nxt  = fits ? rest - operand[CNT_W-1:0] : '0;
            end
            2'd2:    nxt = CAP;
            default: nxt = rest;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    rest <= CAP;
        else if (go && (fits || SAT))  rest <= nxt;
    end
endmodule

module stock_manager #(
    parameter int CH       = 4,
    parameter int CNT_W    = 4,
    parameter int CAPACITY = 15,
    parameter int OP_W     = CNT_W + 4
) (
    input  logic clk,
    input  logic rst_n,
    stock_manager_if.slave bus
);
`ifdef STOCK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ENTRY, APPLY, ERR} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_TAKE = 2'd1, OP_FILL = 2'd2} op_t;

    state_t            state, state_n;
    op_t               opc, opc_n;
    logic [OP_W-1:0]   operand, operand_n;
    logic              done, done_n;

    logic [CH-1:0][CNT_W-1:0] rest_a, room_a;
    logic [CH-1:0]            fits, go;

    // Key decode: anything other than a single set bit is ignored.
    logic              key_one, is_digit, is_a, is_b, is_c, is_d;
    logic [3:0]        digit;
    logic [OP_W+3:0]   acc;

    assign key_one  = $onehot(bus.key_edge);
    assign is_digit = key_one && (|bus.key_edge[9:0]);
    assign is_a     = key_one && bus.key_edge[10];
    assign is_b     = key_one && bus.key_edge[11];
    assign is_c     = key_one && bus.key_edge[12];
    assign is_d     = key_one && bus.key_edge[13];

    always_comb begin
        digit = '0;
        for (int i = 0; i < 10; i++)
            if (bus.key_edge[i]) digit = 4'(i);
    end

    // operand*10 + d fits in OP_W+4 bits for any OP_W-bit operand.
    assign acc = (OP_W+4)'(operand) * (OP_W+4)'(10) + (OP_W+4)'(digit);

    logic sel_ok, sel_fits;
    assign sel_ok   = $onehot(bus.sel);
    assign sel_fits = |(fits & bus.sel);

    always_comb begin
        state_n   = state;
        opc_n     = opc;
        operand_n = operand;
        done_n    = 1'b0;
        case (state)
            IDLE: begin
                if (is_digit) begin
                    operand_n = OP_W'(digit);
                    state_n   = ENTRY;
                end else if (is_a || is_b || is_d) begin
                    opc_n   = is_a ? OP_ADD : (is_b ? OP_TAKE : OP_FILL);
                    state_n = APPLY;
                end else if (is_c) begin
                    operand_n = '0;
                end
            end
            ENTRY: begin
                if (is_digit) begin
                    operand_n = (acc > (OP_W+4)'({OP_W{1'b1}})) ? {OP_W{1'b1}}
                                                                : OP_W'(acc);
                end else if (is_a || is_b || is_d) begin
                    opc_n   = is_a ? OP_ADD : (is_b ? OP_TAKE : OP_FILL);
                    state_n = APPLY;
                end else if (is_c) begin
                    operand_n = '0;
                    state_n   = IDLE;
                end
            end
            APPLY: begin
                // Keys arriving here are dropped on purpose.
                operand_n = '0;
                if (sel_ok && (sel_fits || SAT)) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    state_n = ERR;
                end
            end
            ERR: begin
                if (is_c) begin
                    operand_n = '0;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            opc     <= OP_ADD;
            operand <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            opc     <= opc_n;
            operand <= operand_n;
            done    <= done_n;
        end
    end

    genvar g;
    generate
        for (g = 0; g < CH; g++) begin : g_lane
            assign go[g] = (state == APPLY) && sel_ok && bus.sel[g];
            stock_lane #(
                .CNT_W(CNT_W), .CAPACITY(CAPACITY), .OP_W(OP_W), .SAT(SAT)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .go      (go[g]),
                .op      (opc),
                .operand (operand),
                .rest    (rest_a[g]),
                .room    (room_a[g]),
                .fits    (fits[g])
            );
        end
    endgenerate

    assign bus.rest    = rest_a;
    assign bus.room    = room_a;
    assign bus.operand = operand;
    assign bus.done    = done;
    assign bus.err     = (state == ERR);
endmodule

// File: tb/tb_stock_manager.sv
// tb_stock_manager
//   Directed test of stock_manager with CH=4, CNT_W=4, CAPACITY=15, OP_W=8.
//   Keys are pulsed for one full cycle, launched and sampled on negedges.
module tb_stock_manager;
    logic clk = 1'b0;
    logic rst_n;
    int   vecs = 0;
    int   errs = 0;
    logic [15:0] exp_r;
    logic [15:0] exp_m;

    always #5 clk = ~clk;

    stock_manager_if #(.CH(4), .CNT_W(4), .OP_W(8)) bus ();

    stock_manager #(.CH(4), .CNT_W(4), .CAPACITY(15), .OP_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic press(input int k);
        @(negedge clk) bus.key_edge = 16'(1) << k;
        @(negedge clk) bus.key_edge = '0;
    endtask

    task automatic calc_room();
        for (int i = 0; i < 4; i++) exp_m[i*4 +: 4] = 4'd15 - exp_r[i*4 +: 4];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.sel = '0; bus.key_edge = '0;
        repeat (3) @(negedge clk);
        vecs++; if (bus.rest !== 16'hFFFF) begin errs++; $display("FAIL reset_rest: got %h want FFFF", bus.rest); end
        vecs++; if (bus.room !== 16'h0000) begin errs++; $display("FAIL reset_room: got %h want 0000", bus.room); end
        vecs++; if (bus.operand !== 8'd0) begin errs++; $display("FAIL reset_operand: got %0d want 0", bus.operand); end
        vecs++; if ({bus.done, bus.err} !== 2'b00) begin errs++; $display("FAIL reset_flags: got %b want 00", {bus.done, bus.err}); end
        rst_n = 1'b1;
        exp_r = 16'hFFFF;
    endtask

    task automatic test_take();
        bus.sel = 4'b0001;
        press(3);
        vecs++; if (bus.operand !== 8'd3) begin errs++; $display("FAIL take_operand: got %0d want 3", bus.operand); end
        press(11);
        vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL take_done_early: got %b want 0", bus.done); end
        @(negedge clk);
        exp_r = 16'hFFFC; calc_room();
        vecs++; if (bus.rest !== exp_r) begin errs++; $display("FAIL take_rest: got %h want %h", bus.rest, exp_r); end
        vecs++; if (bus.room !== exp_m) begin errs++; $display("FAIL take_room: got %h want %h", bus.room, exp_m); end
        vecs++; if (bus.done !== 1'b1) begin errs++; $display("FAIL take_done: got %b want 1", bus.done); end
        vecs++; if (bus.operand !== 8'd0) begin errs++; $display("FAIL take_opclr: got %0d want 0", bus.operand); end
        @(negedge clk);
        vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL take_done_pulse: got %b want 0", bus.done); end
    endtask

    task automatic test_multi_digit();
        press(1); press(2);
        vecs++; if (bus.operand !== 8'd12) begin errs++; $display("FAIL multi_operand: got %0d want 12", bus.operand); end
        press(11); @(negedge clk);
        exp_r = 16'hFFF0;
        vecs++; if (bus.rest !== exp_r) begin errs++; $display("FAIL multi_take: got %h want %h", bus.rest, exp_r); end
        press(1); press(0); press(10); @(negedge clk);
        exp_r = 16'hFFFA; calc_room();
        vecs++; if (bus.rest !== exp_r) begin errs++; $display("FAIL multi_add: got %h want %h", bus.rest, exp_r); end
        vecs++; if (bus.room !== exp_m) begin errs++; $display("FAIL multi_room: got %h want %h", bus.room, exp_m); end
    endtask

    task automatic test_overflow();
        press(9); press(10); @(negedge clk);
`ifdef STOCK_SATURATE_EN
        exp_r = 16'hFFFF;
        vecs++; if (bus.rest !== exp_r) begin errs++; $display("FAIL ovf_rest: got %h want %h", bus.rest, exp_r); end
        vecs++; if ({bus.done, bus.err} !== 2'b10) begin errs++; $display("FAIL ovf_flags: got %b want 10", {bus.done, bus.err}); end
`else
        vecs++; if (bus.rest !== exp_r) begin errs++; $display("FAIL ovf_rest: got %h want %h", bus.rest, exp_r); end
        vecs++; if ({bus.done, bus.err} !== 2'b01) begin errs++; $display("FAIL ovf_flags: got %b want 01", {bus.done, bus.err}); end
        press(5);
        vecs++; if ({bus.err, bus.operand} !== {1'b1, 8'd0}) begin errs++; $display("FAIL ovf_err_hold: got %b/%0d want 1/0", bus.err, bus.operand); end
`endif
        press(12);
        vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b want 0", bus.err); end
    endtask

    task automatic test_bad_select();
        for (int r = 0; r < 2; r++) begin
            bus.sel = (r == 0) ? 4'b0011 : 4'b0000;
            press(2); press(10); @(negedge clk);
            vecs++; if ({bus.done, bus.err} !== 2'b01) begin errs++; $display("FAIL badsel_flags%0d: got %b want 01", r, {bus.done, bus.err}); end
            vecs++; if (bus.rest !== exp_r) begin errs++; $display("FAIL badsel_rest%0d: got %h want %h", r, bus.rest, exp_r); end
            press(12);
            vecs++; if (bus.err !== 1'b0) begin errs++; $display("FAIL badsel_clear%0d: got %b want 0", r, bus.err); end
        end
    endtask

    task automatic test_refill_clear();
        bus.sel = 4'b0100;
        press(1); press(1); press(11); @(negedge clk);
        exp_r[11:8] = 4'd4;
        vecs++; if (bus.rest !== exp_r) begin errs++; $display("FAIL refill_pre: got %h want %h", bus.rest, exp_r); end
        press(13); @(negedge clk);
        exp_r[11:8] = 4'd15; calc_room();
        vecs++; if (bus.rest !== exp_r || bus.done !== 1'b1) begin errs++; $display("FAIL refill_rest: got %h/%b want %h/1", bus.rest, bus.done, exp_r); end
        vecs++; if (bus.room !== exp_m) begin errs++; $display("FAIL refill_room: got %h want %h", bus.room, exp_m); end
        press(5); press(12);
        vecs++; if (bus.operand !== 8'd0) begin errs++; $display("FAIL clear_operand: got %0d want 0", bus.operand); end
        // A digit from IDLE loads rather than appends.
        press(7);
        vecs++; if (bus.operand !== 8'd7) begin errs++; $display("FAIL clear_idle: got %0d want 7", bus.operand); end
        press(12);
    endtask

    task automatic test_key_filter();
        press(4);
        @(negedge clk) bus.key_edge = 16'h0018;
        @(negedge clk) bus.key_edge = 16'h4000;
        @(negedge clk) bus.key_edge = '0;
        vecs++; if (bus.operand !== 8'd4) begin errs++; $display("FAIL key_filter: got %0d want 4", bus.operand); end
        press(9); press(9);
        vecs++; if (bus.operand !== 8'd255) begin errs++; $display("FAIL operand_sat: got %0d want 255", bus.operand); end
        press(12);
    endtask

    task automatic test_back_to_back();
        bus.sel = 4'b1000;
        press(2); press(11);
        bus.key_edge = 16'h0020;   // arrives during APPLY
        @(negedge clk) bus.key_edge = '0;
        exp_r[15:12] = 4'd13;
        vecs++; if (bus.rest !== exp_r || bus.done !== 1'b1) begin errs++; $display("FAIL drop_rest: got %h/%b want %h/1", bus.rest, bus.done, exp_r); end
        vecs++; if (bus.operand !== 8'd0) begin errs++; $display("FAIL drop_operand: got %0d want 0", bus.operand); end
    endtask

    task automatic test_async_reset();
        bus.sel = 4'b0001;
        press(1); press(10);
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (bus.rest !== 16'hFFFF || bus.room !== 16'h0000) begin errs++; $display("FAIL arst_counts: got %h/%h want FFFF/0000", bus.rest, bus.room); end
        vecs++; if ({bus.done, bus.err, bus.operand} !== 10'd0) begin errs++; $display("FAIL arst_flags: got %b/%b/%0d want 0/0/0", bus.done, bus.err, bus.operand); end
        @(negedge clk);
        vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL arst_nodone: got %b want 0", bus.done); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_take();
        test_multi_digit();
        test_overflow();
        test_bad_select();
        test_refill_clear();
        test_key_filter();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/stock_manager.md
# stock_manager

Parametrised per-channel stock/occupancy manager for the keypad-and-switch front panel. It holds CH independent counters of CNT_W bits, each bounded by CAPACITY. Decimal quantities are entered on the 4x4 keypad and applied as add or take operations to the channel chosen by the one-hot select switches. It sits between the keypad decoder (key_edge) and the seven-segment display driver, and exports the remaining count and free room per channel.

## Interface
- CH, 4, number of channels (1..8)
- CNT_W, 4, counter width per channel
- CAPACITY, 15, maximum count per channel (must be ≤ 2^CNT_W−1)
- OP_W, CNT_W+4, width of the keypad operand accumulator

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- sel  in  CH  channel select; must be exactly one-hot for a command to act
- key_edge  in  16  one-cycle key-press pulses; bits 0–9 are digits 0–9, 10=A (add), 11=B (take), 12=C (clear), 13=D (refill selected channel to CAPACITY), 14/15 are ignored
- rest  out  CH*CNT_W  current count of channel i at [i*CNT_W +: CNT_W]
- room  out  CH*CNT_W  CAPACITY − rest, same packing
- operand  out  OP_W  current entry value, for display
- done  out  1  one-cycle pulse when a command is applied
- err  out  1  high while in ERR state

## Operation
- States: IDLE, ENTRY, APPLY, ERR.
- A key_edge value with more than one bit set is ignored in every state.
- IDLE: a digit d loads operand=d and moves to ENTRY. A, B or D moves to APPLY with the current operand, which is 0 after reset. C keeps operand at 0.
- ENTRY: a digit d gives operand = operand*10 + d, saturating at 2^OP_W−1. A, B or D latches the opcode and moves to APPLY. C sets operand=0 and moves to IDLE.
- APPLY takes exactly one cycle. The target channel is sel, sampled in this cycle.
  - If sel is not one-hot: no count changes, go to ERR.
  - A, operand ≤ room[ch]: rest[ch] += operand, pulse done, go to IDLE.
  - A, operand > room[ch]: go to ERR.
  - B, operand ≤ rest[ch]: rest[ch] −= operand, pulse done, go to IDLE.
  - B, operand > rest[ch]: go to ERR.
  - D: rest[ch] = CAPACITY, pulse done, go to IDLE.
  - On every exit from APPLY, operand is cleared to 0.
- ERR: the counts and operand are held. Only C leaves ERR, going to IDLE with operand=0. All other keys are ignored.
- Arithmetic is done at OP_W+1 bits, so the comparisons cannot wrap. Counts never leave the range 0..CAPACITY.
- room is combinational from rest.
- Reset values: rest = CAPACITY on all channels, room = 0, operand = 0, done = 0, err = 0, state = IDLE.

## Timing
- A key_edge pulse at cycle T updates state and operand at the edge ending T.
- For a command key at T: APPLY is active during T+1. rest and room show the new value and done is high during T+2.
- err rises in T+2 when APPLY fails.
- Key pulses that arrive while in APPLY are dropped.
- Reset assertion mid-operation immediately forces all reset values, including when it occurs during APPLY.

## Configuration
- STOCK_SATURATE_EN defined:
  - An oversized A clamps rest[ch] to CAPACITY.
  - An oversized B clamps rest[ch] to 0.
  - Both pulse done and go to IDLE.
  - ERR is reached only for a non-one-hot sel.
- STOCK_SATURATE_EN undefined: the error behaviour in the Operation section applies.

## Test plan
- Reset, then take: after reset, rest = CAPACITY = 15 on all channels. With sel=0001, keys 3, B → rest0=12, room0=3, done pulses once, other channels stay at 15.
- Multi-digit add: from rest0=12, keys 1, 2, B gives rest0=0. Then keys 1, 0, A gives rest0=10.
- Overflow add: with rest0=10, key 9 then A.
  - Without the macro: err=1 and rest0 stays 10. Key C then clears err.
  - With STOCK_SATURATE_EN: rest0=15, done pulses and err stays 0.
- Bad select: sel=0011, keys 2, A → ERR and all counts unchanged. Repeat with sel=0000 → same result.
- Refill and clear: with sel=0100 and rest2=4, key D → rest2=15. Keys 5, C → operand=0 and state IDLE.
- Async reset during APPLY: assert rst_n low in the APPLY cycle → all outputs take reset values within the same cycle, and no done pulse occurs.
